mu0_reg_ctr: RTL

//   Parametrised multi-mode register for the MU0 datapath. Generalises the plain 12-bit

---
 rtl/mu0_reg_ctr.sv | 85 ++++++++
 1 files changed

// File: rtl/mu0_reg_ctr.sv
// mu0_reg_ctr: multi-mode MU0 datapath register. It can load, increment,
// decrement or hold, and has a synchronous clear. Inc/dec either wrap or
// saturate. Zero and overflow status are registered.
//
// Ports:
//   Clk    in   1      clock, rising edge
//   Reset  in   1      asynchronous active-high reset (Q <= RESET_VAL)
//   Clr    in   1      synchronous clear, overrides En/Op
//   En     in   1      operation enable; Q holds when low
//   Op     in   2      00 load D, 01 increment, 10 decrement, 11 hold
//   D      in   WIDTH  load data
//   Q      out  WIDTH  register value
//   Zero   out  1      high when Q == 0 (updated on the same edge as Q)
//   Ovf    out  1      one-cycle pulse: inc at all-ones or dec at zero
module mu0_reg_ctr #(
  parameter int unsigned          WIDTH     = 12,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter bit                   SATURATE  = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr,
  input  logic             En,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Zero,
  output logic             Ovf
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_HOLD = 2'b11
  } op_t;

  logic [WIDTH-1:0] q_next;
  logic             ovf_next;

  // Next state is computed once here, so Zero can come from q_next.
  // This keeps Zero in step with Q instead of one cycle behind.
  always_comb begin
    q_next   = Q;
    ovf_next = 1'b0;
    if (Clr) begin
      q_next = '0;
    end else if (En) begin
      unique case (op_t'(Op))
        OP_LOAD: q_next = D;
        OP_INC: begin
          if (Q == '1) begin
            q_next   = SATURATE ? '1 : '0;
            ovf_next = 1'b1;
          end else begin
            q_next = Q + WIDTH'(1);
          end
        end
        OP_DEC: begin
          if (Q == '0) begin
            q_next   = SATURATE ? '0 : '1;
            ovf_next = 1'b1;
          end else begin
            q_next = Q - WIDTH'(1);
          end
        end
        OP_HOLD: q_next = Q;
        default: q_next = Q;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Q    <= RESET_VAL;
      Zero <= (RESET_VAL == '0);
      Ovf  <= 1'b0;
    end else begin
      Q    <= q_next;
      Zero <= (q_next == '0);
      Ovf  <= ovf_next;
    end
  end

endmodule
